// File: rtl/psk_mod_pkg.sv
// Shared definitions for the PSK modulator front end.
//   state_t        : sequencer states of the symbol upsampler
//   MOD_BPSK/QPSK  : encodings of the mod_sel input
//   ONE_Q14        : 1.0 in signed Q2.14
//   INV_SQRT2_Q14  : 1/sqrt(2) in signed Q2.14 (QPSK per-rail magnitude)
package psk_mod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MOD_BPSK = 1'b0;
  localparam logic MOD_QPSK = 1'b1;

  localparam int ONE_Q14       = 16384;
  localparam int INV_SQRT2_Q14 = 11585;

endpackage

// File: rtl/psk_constellation_map.sv
// Combinational symbol-to-constellation mapper (BPSK / Gray-coded QPSK).
// Bit value 0 maps to +AMP, 1 maps to -AMP.
//   mod_sel : MOD_BPSK or MOD_QPSK
//   bits    : symbol bits; BPSK uses bits[0] only
//   i_val   : in-phase value, signed
//   q_val   : quadrature value, signed
module psk_constellation_map
  import psk_mod_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BPSK_AMP   = ONE_Q14,
  parameter int QPSK_AMP   = INV_SQRT2_Q14
) (
  input  logic                         mod_sel,
  input  logic [1:0]                   bits,
  output logic signed [DATA_WIDTH-1:0] i_val,
  output logic signed [DATA_WIDTH-1:0] q_val
);

  localparam logic signed [DATA_WIDTH-1:0] BPSK_P = DATA_WIDTH'(BPSK_AMP);
  localparam logic signed [DATA_WIDTH-1:0] BPSK_N = DATA_WIDTH'(-BPSK_AMP);
  localparam logic signed [DATA_WIDTH-1:0] QPSK_P = DATA_WIDTH'(QPSK_AMP);
  localparam logic signed [DATA_WIDTH-1:0] QPSK_N = DATA_WIDTH'(-QPSK_AMP);

  always_comb begin
    i_val = '0;
    q_val = '0;
    if (mod_sel == MOD_QPSK) begin
      i_val = bits[1] ? QPSK_N : QPSK_P;
      q_val = bits[0] ? QPSK_N : QPSK_P;
    end else begin
      i_val = bits[0] ? BPSK_N : BPSK_P;
    end
  end

endmodule

// File: rtl/psk_symbol_upsampler.sv
// Symbol upsampler feeding the pulse-shaping FIRs of the PSK modulator.
// Takes symbols over valid/ready, maps them to BPSK/QPSK in signed Q2.14,
// zero-stuffs each to SPS samples and strobes one sample every SAMPLE_DIV
// clocks.
//   clk, rst         : clock, asynchronous active-high reset
//   enable           : run request (level)
//   mod_sel, bits_in : symbol modulation and bits, captured at handshake
//   bits_valid/ready : input handshake
//   i_out, q_out     : output sample, valid while sample_en is high
//   sample_en        : one-cycle sample strobe
//   symbol_strobe    : sample_en on phase-0 samples
//   underflow        : phase-0 slot in RUN found no symbol waiting
//
// state | meaning
// IDLE  | stopped, counters cleared, holding register discarded
// RUN   | emitting samples, accepting symbols
// DRAIN | enable dropped, finishing the current symbol period, no accepts
module psk_symbol_upsampler
  import psk_mod_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_FRAC_WIDTH = 14,
  parameter int SPS             = 4,
  parameter int SAMPLE_DIV      = 2,
  parameter int BPSK_AMP        = 1 << DATA_FRAC_WIDTH,
  parameter int QPSK_AMP        = INV_SQRT2_Q14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         mod_sel,
  input  logic [1:0]                   bits_in,
  input  logic                         bits_valid,
  output logic                         bits_ready,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] q_out,
  output logic                         sample_en,
  output logic                         symbol_strobe,
  output logic                         underflow
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PH_W  = $clog2(SPS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SPS - 1);

  state_t                  state;
  logic [DIV_W-1:0]        div_cnt;
  logic [PH_W-1:0]         phase;
  logic                    full;
  logic [2:0]              hold;
  logic                    active;
  logic                    tick;
  logic                    consume_now;
  logic                    load;
  logic signed [DATA_WIDTH-1:0] map_i;
  logic signed [DATA_WIDTH-1:0] map_q;

  assign active      = (state != IDLE);
  assign tick        = active && (div_cnt == DIV_LAST);
  assign consume_now = tick && (phase == '0);
  // The slot being emitted this cycle frees the register, so a new symbol
  // can be taken in the same cycle the old one is consumed.
  assign bits_ready  = (state == RUN) && (!full || consume_now);
  assign load        = bits_valid && bits_ready;

  psk_constellation_map #(
    .DATA_WIDTH (DATA_WIDTH),
    .BPSK_AMP   (BPSK_AMP),
    .QPSK_AMP   (QPSK_AMP)
  ) u_map (
    .mod_sel (hold[2]),
    .bits    (hold[1:0]),
    .i_val   (map_i),
    .q_val   (map_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      phase         <= '0;
      full          <= 1'b0;
      hold          <= '0;
      i_out         <= '0;
      q_out         <= '0;
      sample_en     <= 1'b0;
      symbol_strobe <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      sample_en     <= tick;
      symbol_strobe <= consume_now;
      underflow     <= consume_now && !full && (state == RUN);

      if (tick) begin
        if (consume_now && full) begin
          i_out <= map_i;
          q_out <= map_q;
        end else begin
          i_out <= '0;
          q_out <= '0;
        end
      end

      if (!active) begin
        div_cnt <= '0;
        phase   <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        phase   <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state == IDLE) begin
        full <= 1'b0;
      end else begin
        full <= load || (full && !consume_now);
      end
      if (load) begin
        hold <= {mod_sel, bits_in};
      end

      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable) state <= RUN;
          else if (tick && (phase == PH_LAST)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psk_symbol_upsampler.sv
// Directed self-checking bench for psk_symbol_upsampler (SPS=4, SAMPLE_DIV=2).
module tb_psk_symbol_upsampler;
  import psk_mod_pkg::*;

  localparam int QA = 11585;
  localparam int BA = 16384;

  logic tb_clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic mod_sel = 1'b0;
  logic [1:0] bits_in = 2'b00;
  logic bits_valid = 1'b0;
  logic bits_ready;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic sample_en;
  logic symbol_strobe;
  logic underflow;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_at = 0;

  psk_symbol_upsampler #(
    .DATA_WIDTH      (16),
    .DATA_FRAC_WIDTH (14),
    .SPS             (4),
    .SAMPLE_DIV      (2),
    .BPSK_AMP        (16384),
    .QPSK_AMP        (11585)
  ) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .enable        (enable),
    .mod_sel       (mod_sel),
    .bits_in       (bits_in),
    .bits_valid    (bits_valid),
    .bits_ready    (bits_ready),
    .i_out         (i_out),
    .q_out         (q_out),
    .sample_en     (sample_en),
    .symbol_strobe (symbol_strobe),
    .underflow     (underflow)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    bits_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic m, input logic [1:0] b, output int acc_at);
    int guard;
    guard = 0;
    mod_sel = m;
    bits_in = b;
    bits_valid = 1'b1;
    while (!bits_ready && guard < 40) begin
      step();
      guard++;
    end
    check_val("send_timeout", (guard < 40) ? 1 : 0, 1);
    step();
    acc_at = cyc;
    bits_valid = 1'b0;
  endtask

  task automatic chk_sample(input string tag, input int ei, input int eq,
                            input logic est, input logic euf, input int egap);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!sample_en && guard < 32);
    check_val({tag, "_en"}, sample_en, 1);
    check_val({tag, "_i"}, i_out, ei);
    check_val({tag, "_q"}, q_out, eq);
    check_val({tag, "_strobe"}, symbol_strobe, est);
    check_val({tag, "_uf"}, underflow, euf);
    if (egap > 0) check_val({tag, "_gap"}, cyc - last_at, egap);
    last_at = cyc;
  endtask

  initial begin
    int t0;
    int acc[4];
    int n_en, n_uf, n_rdy;

    // reset state, observed while reset is held
    #2;
    check_val("rst_i", i_out, 0);
    check_val("rst_q", q_out, 0);
    check_val("rst_en", sample_en, 0);
    check_val("rst_strobe", symbol_strobe, 0);
    check_val("rst_uf", underflow, 0);
    check_val("rst_ready", bits_ready, 0);

    // QPSK 00 then 11
    do_reset();
    enable = 1'b1;
    t0 = cyc;
    fork
      begin
        send(MOD_QPSK, 2'b00, acc[0]);
        send(MOD_QPSK, 2'b11, acc[1]);
      end
      begin
        chk_sample("qa0", QA, QA, 1, 0, 0);
        check_val("qa_latency", last_at - t0, 3);
        chk_sample("qa1", 0, 0, 0, 0, 2);
        chk_sample("qa2", 0, 0, 0, 0, 2);
        chk_sample("qa3", 0, 0, 0, 0, 2);
        chk_sample("qa4", -QA, -QA, 1, 0, 2);
        chk_sample("qa5", 0, 0, 0, 0, 2);
        chk_sample("qa6", 0, 0, 0, 0, 2);
        chk_sample("qa7", 0, 0, 0, 0, 2);
      end
    join

    // BPSK: bit0=1 then bit0=0; bit 1 must be ignored
    do_reset();
    enable = 1'b1;
    fork
      begin
        send(MOD_BPSK, 2'b11, acc[0]);
        send(MOD_BPSK, 2'b10, acc[1]);
      end
      begin
        chk_sample("bp0", -BA, 0, 1, 0, 0);
        chk_sample("bp1", 0, 0, 0, 0, 2);
        chk_sample("bp2", 0, 0, 0, 0, 2);
        chk_sample("bp3", 0, 0, 0, 0, 2);
        chk_sample("bp4", BA, 0, 1, 0, 2);
        chk_sample("bp5", 0, 0, 0, 0, 2);
      end
    join

    // no symbols: zeros and an underflow every phase-0 slot
    do_reset();
    enable = 1'b1;
    chk_sample("uf0", 0, 0, 1, 1, 0);
    t0 = last_at;
    chk_sample("uf1", 0, 0, 0, 0, 2);
    chk_sample("uf2", 0, 0, 0, 0, 2);
    chk_sample("uf3", 0, 0, 0, 0, 2);
    chk_sample("uf4", 0, 0, 1, 1, 2);
    check_val("uf_period", last_at - t0, 8);

    // four back-to-back QPSK symbols
    do_reset();
    enable = 1'b1;
    fork
      begin
        send(MOD_QPSK, 2'b01, acc[0]);
        send(MOD_QPSK, 2'b10, acc[1]);
        send(MOD_QPSK, 2'b11, acc[2]);
        send(MOD_QPSK, 2'b00, acc[3]);
      end
      begin
        chk_sample("bb0", QA, -QA, 1, 0, 0);
        for (int k = 0; k < 3; k++) chk_sample("bb0z", 0, 0, 0, 0, 2);
        chk_sample("bb1", -QA, QA, 1, 0, 2);
        for (int k = 0; k < 3; k++) chk_sample("bb1z", 0, 0, 0, 0, 2);
        chk_sample("bb2", -QA, -QA, 1, 0, 2);
        for (int k = 0; k < 3; k++) chk_sample("bb2z", 0, 0, 0, 0, 2);
        chk_sample("bb3", QA, QA, 1, 0, 2);
      end
    join
    check_val("bb_acc_gap2", acc[2] - acc[1], 8);
    check_val("bb_acc_gap3", acc[3] - acc[2], 8);

    // enable dropped after the phase-1 sample
    do_reset();
    mod_sel = MOD_QPSK;
    bits_in = 2'b00;
    bits_valid = 1'b1;
    enable = 1'b1;
    chk_sample("dr0", QA, QA, 1, 0, 0);
    chk_sample("dr1", 0, 0, 0, 0, 2);
    enable = 1'b0;
    step();
    check_val("dr_ready_off", bits_ready, 0);
    n_en = 0;
    n_uf = 0;
    n_rdy = 0;
    for (int k = 0; k < 14; k++) begin
      if (sample_en) n_en++;
      if (underflow) n_uf++;
      if (bits_ready) n_rdy++;
      step();
    end
    check_val("dr_samples", n_en, 2);
    check_val("dr_uf", n_uf, 0);
    check_val("dr_ready_cnt", n_rdy, 0);
    // the symbol left in the register must have been discarded
    bits_valid = 1'b0;
    enable = 1'b1;
    chk_sample("dr_restart", 0, 0, 1, 1, 0);

    // reset between clock edges mid-symbol
    do_reset();
    enable = 1'b1;
    fork
      send(MOD_QPSK, 2'b11, acc[0]);
      chk_sample("rs0", -QA, -QA, 1, 0, 0);
    join
    check_val("rs_pre_ready", bits_ready, 1);
    #3;
    rst = 1'b1;
    #1;
    check_val("rs_i", i_out, 0);
    check_val("rs_q", q_out, 0);
    check_val("rs_en", sample_en, 0);
    check_val("rs_ready", bits_ready, 0);
    @(posedge tb_clk);
    #1;
    rst = 1'b0;
    t0 = cyc;
    chk_sample("rs_first", 0, 0, 1, 1, 0);
    check_val("rs_latency", last_at - t0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
